// File: rtl/send_pkg.sv
// Shared types and constants for the multisend channel arbiter.
package send_pkg;

  localparam int unsigned ClkHz            = 12_000_000;
  localparam int unsigned DefGapCycles     = ClkHz / 10;
  localparam int unsigned DefTimeoutCycles = ClkHz * 10;
  localparam int unsigned CntW             = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StGap  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic            valid,
  output logic [2:0]      index
);

  logic [7:0] req_pad;
  logic [2:0] k;

  always_comb begin
    req_pad = 8'(req);
    valid   = 1'b0;
    index   = '0;
    k       = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      k = 3'((32'(last) + 32'(i)) % NREQ);
      if (!valid && req_pad[k]) begin
        valid = 1'b1;
        index = k;
      end
    end
  end

endmodule

// File: rtl/send_arbiter.sv
// Round-robin arbiter sharing one multisend channel; enforces blanking, timeout and idle gap.
module send_arbiter
  import send_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned GAP_CYCLES     = DefGapCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned BLANK_CYCLES   = 2
) (
  input  logic              hwclk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] num_flat,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [31:0]       sender_num,
  output logic              sender_en,
  input  logic              sender_done
);

  state_e          state;
  logic [2:0]      last;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic [31:0]     nums [8];

  // Pad to eight slots so a 3-bit index never selects out of range.
  for (genvar g = 0; g < 8; g++) begin : g_num
    if (g < NREQ) begin : g_used
      assign nums[g] = num_flat[32*g +: 32];
    end else begin : g_pad
      assign nums[g] = '0;
    end
  end

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .valid(pick_valid),
    .index(pick_idx)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign busy    = (state != StIdle);

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state      <= StIdle;
      last       <= 3'(NREQ - 1);
      cnt        <= '0;
      grant_id   <= '0;
      sender_num <= '0;
      sender_en  <= 1'b0;
      ack        <= '0;
      err        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            grant_id   <= pick_idx;
            last       <= pick_idx;
            sender_num <= nums[pick_idx];
            state      <= StArm;
          end
        end
        StArm: begin
          sender_en <= 1'b1;
          cnt       <= '0;
          state     <= StRun;
        end
        StRun: begin
          cnt <= cnt_inc;
          // Done is checked first so it wins over a coincident timeout.
          if (cnt >= BLANK_CYCLES && sender_done) begin
            ack       <= NREQ'(32'd1 << grant_id);
            sender_en <= 1'b0;
            cnt       <= '0;
            state     <= StGap;
          end else if (cnt_inc >= TIMEOUT_CYCLES) begin
            err       <= NREQ'(32'd1 << grant_id);
            sender_en <= 1'b0;
            cnt       <= '0;
            state     <= StGap;
          end
        end
        StGap: begin
          cnt <= cnt_inc;
          if (cnt_inc >= GAP_CYCLES) begin
            cnt   <= '0;
            state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Randomized transaction-level bench for send_arbiter with a behavioural channel model.
module tb_send_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned GAP     = 10;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned BLANK   = 2;
  localparam int          NEVER   = 100000;

  logic                 hwclk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   num_flat;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic [2:0]           grant_id;
  logic [31:0]          sender_num;
  logic                 sender_en;
  logic                 sender_done;

  logic [31:0] nums [NREQ];
  int          m_last;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 hwclk = ~hwclk;

  always_comb begin
    num_flat = '0;
    for (int i = 0; i < int'(NREQ); i++) num_flat[32*i +: 32] = nums[i];
  end

  send_arbiter #(
    .NREQ          (NREQ),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .BLANK_CYCLES  (BLANK)
  ) dut (
    .hwclk      (hwclk),
    .rst_n      (rst_n),
    .req        (req),
    .num_flat   (num_flat),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id),
    .sender_num (sender_num),
    .sender_en  (sender_en),
    .sender_done(sender_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  // Round-robin rule: search last+1, last+2, ... modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] rq, input int last);
    for (int off = 1; off <= int'(NREQ); off++) begin
      if (rq[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  // Channel done level as seen in RUN cycle k (0 = first cycle with enable high).
  function automatic bit done_at(input int k, input int dly, input bit stale);
    return (k >= dly) || (stale && k == 0);
  endfunction

  task automatic do_transfer(input logic [NREQ-1:0] rq, input int dly, input bit stale,
                             input int drop_at);
    int w, acc, len_exp, lat, k, gap, extra;
    logic [31:0] exp_ack, exp_err;
    w = model_pick(rq, m_last);
    acc = -1;
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      if (acc < 0 && c >= int'(BLANK) && done_at(c, dly, stale)) acc = c;
    end
    len_exp = (acc >= 0) ? acc + 1 : int'(TIMEOUT);
    exp_ack = (acc >= 0) ? (32'd1 << w) : 32'd0;
    exp_err = (acc < 0) ? (32'd1 << w) : 32'd0;
    m_last = w;

    req = rq;
    sender_done = stale;
    lat = 0;
    while (!sender_en && lat < 10) begin
      step();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd2);
    check_eq("grant_id", 32'(grant_id), 32'(w));
    check_eq("sender_num", sender_num, nums[w]);

    k = 0;
    extra = 0;
    while (sender_en && k < int'(TIMEOUT) + 10) begin
      sender_done = done_at(k, dly, stale);
      if (k == drop_at) req = '0;
      step();
      k++;
      if (sender_num !== nums[w] || (ack | err) != '0 && sender_en) extra++;
    end
    sender_done = 1'b0;
    check_eq("run_len", 32'(k), 32'(len_exp));
    check_eq("ack", 32'(ack), exp_ack);
    check_eq("err", 32'(err), exp_err);

    gap = 0;
    while (busy && gap < int'(GAP) + 10) begin
      if (sender_en) extra++;
      step();
      gap++;
      if ((ack | err) != '0 || sender_num !== nums[w]) extra++;
    end
    check_eq("gap_len", 32'(gap), 32'(GAP));
    check_eq("extra_events", 32'(extra), 32'd0);
  endtask

  task automatic randomize_nums();
    for (int i = 0; i < int'(NREQ); i++) nums[i] = $urandom;
  endtask

  initial begin
    int idle_busy;
    rst_n = 1'b0;
    req = '0;
    sender_done = 1'b0;
    randomize_nums();
    m_last = NREQ - 1;
    step();
    step();
    check_eq("rst_en", 32'(sender_en), 32'd0);
    check_eq("rst_num", sender_num, 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    step();

    // Contention: all requesters held, expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++) do_transfer(4'b1111, 5 + i, 1'b0, -1);

    // Single request with a known value.
    nums[0] = 32'd123456;
    do_transfer(4'b0001, 40, 1'b0, -1);

    // Stale done at enable rise must be masked by blanking.
    do_transfer(4'b0100, 6, 1'b1, -1);
    do_transfer(4'b0010, 0, 1'b1, -1);

    // Timeout, then done coinciding with timeout.
    do_transfer(4'b0010, NEVER, 1'b0, -1);
    do_transfer(4'b1000, int'(TIMEOUT) - 1, 1'b0, -1);

    // Requester withdraws mid-run: still acked, then no re-grant.
    do_transfer(4'b0001, 20, 1'b0, 8);
    idle_busy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy || sender_en) idle_busy++;
    end
    check_eq("no_regrant", 32'(idle_busy), 32'd0);

    // Reset in the middle of a run.
    req = 4'b0010;
    for (int i = 0; i < 8; i++) step();
    req = '0;
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_en", 32'(sender_en), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ackerr", 32'(ack | err), 32'd0);
    rst_n = 1'b1;
    m_last = NREQ - 1;
    do_transfer(4'b1111, 3, 1'b0, -1);

    // Random traffic.
    for (int t = 0; t < 20; t++) begin
      randomize_nums();
      do_transfer(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 120)),
                  1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/send_arbiter.md
Name: send_arbiter

Overview:
- Shares one multisend digit-transmit channel between NREQ requesters, e.g. the keypad echo, lock-status code and error code sources.
- Round-robin grant. Latches the winning requester's 32-bit number and drives the multisend enable.
- Waits for the done level, then enforces an idle gap so the receiver sees separate messages.
- Sits between the keylock control logic and the multisend instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 1200000, minimum cycles with sender_en low between transfers (0.1 s at 12 MHz).
- TIMEOUT_CYCLES, 120000000, maximum cycles waiting for sender_done before the transfer is aborted (10 s).
- BLANK_CYCLES, 2, cycles after the sender_en rise during which sender_done is ignored.

Ports:
- hwclk  in  1  system clock. Only clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the hwclk rising edge.
- req  in  NREQ  level request per requester. Held until ack.
- num_flat  in  32*NREQ  value per requester; requester k uses bits [32k+31:32k]. Must be stable while req[k] is high.
- ack  out  NREQ  one-cycle pulse to the granted requester on successful completion.
- err  out  NREQ  one-cycle pulse to the granted requester on timeout.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.
- sender_num  out  32  number presented to multisend.
- sender_en  out  1  multisend enabled input.
- sender_done  in  1  multisend done level.

Behaviour:
- Reset (rst_n=0 on a clock edge), applied to all registers:
  - state=IDLE; sender_en=0; sender_num=0; ack=0; err=0; busy=0; grant_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - All counters cleared.
- Reset mid-transfer behaves the same: sender_en drops on that edge and no ack or err is issued.
- States: IDLE, ARM, RUN, GAP.
- IDLE:
  - If req is non-zero, grant the first set bit searching last+1, last+2, ... with modulo NREQ wrap.
  - On the same edge: grant_id<=winner, last<=winner, sender_num<=that requester's num, go to ARM.
  - req is sampled only in IDLE.
- ARM: exactly 1 cycle with sender_en=0 and sender_num stable. Next edge: sender_en<=1, clear counters, go to RUN.
- RUN:
  - sender_en=1. Cycle counter increments every cycle.
  - sender_done is ignored while the counter is below BLANK_CYCLES; this masks a stale done from the previous transfer.
  - After blanking, the first cycle with sender_done=1 causes: ack[grant_id] pulses for 1 cycle, sender_en<=0, go to GAP.
  - If the counter reaches TIMEOUT_CYCLES first: err[grant_id] pulses for 1 cycle, sender_en<=0, go to GAP.
  - If done and timeout occur in the same cycle, done wins (ack only).
- GAP: sender_en=0 for exactly GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, GAP lasts 1 cycle.
- Request handling:
  - req[k] dropping during ARM, RUN or GAP does not abort the transfer; ack or err is still pulsed.
  - A requester still asserting req when the arbiter returns to IDLE is treated as a new request. Requesters must drop req within GAP_CYCLES of ack.
- Latency from req rising (arbiter in IDLE) to sender_en rising: 2 cycles.
- At most one bit of ack|err is set at any time.
- sender_num changes only on the IDLE->ARM edge.
- Counters are 32-bit unsigned, saturating; no wrap.

Decomposition:
- Shared package send_pkg holds:
  - state encoding constants (IDLE=0, ARM=1, RUN=2, GAP=3);
  - the default GAP/TIMEOUT constants derived from a 12 MHz clock;
  - a 32-bit counter width constant.
- One sub-module, rr_pick: combinational round-robin selector with inputs req and last, outputs valid and index.

Test Plan:
- Single request: reset, req=0001, num0=123456; done model rises 40 cycles after en -> sender_en rises at cycle 2, sender_num=123456, ack=0001 for 1 cycle, sender_en low for GAP_CYCLES (bench GAP_CYCLES=10).
- Contention: req=1111 held and re-raised after each ack -> grant order 0,1,2,3,0; each transfer separated by ≥10 low cycles of sender_en.
- Stale done: sender_done held high from a previous transfer for 1 cycle after the en rise, BLANK_CYCLES=2 -> no ack until the real done rises.
- Timeout: TIMEOUT_CYCLES=100, done never rises -> err[grant_id] pulse at RUN cycle 100, no ack, GAP then IDLE. Done and timeout in the same cycle -> ack only.
- Reset mid-RUN: rst_n=0 one cycle -> sender_en=0, busy=0, ack=err=0 next edge; the next grant goes to requester 0.
- Requester withdraws: req drops in RUN -> transfer completes, ack still pulsed, no re-grant.
